// File: rtl/box_update_sched.sv
// Round-robin scheduler for on-screen box bound updates. Updates are staged in
// shadow registers and copied to the outputs only at a frame boundary.
module box_update_sched #(
  parameter int NUM_OBJ = 4,
  parameter int SCR_W   = 640,
  parameter int SCR_H   = 480
) (
  input  logic                   clk_25mHz,
  input  logic                   reset,
  input  logic                   screenEnd,
  input  logic [NUM_OBJ-1:0]     req,
  input  logic [10*NUM_OBJ-1:0]  req_x,
  input  logic [9*NUM_OBJ-1:0]   req_y,
  input  logic [6*NUM_OBJ-1:0]   req_half,
  output logic [NUM_OBJ-1:0]     ack,
  output logic [10*NUM_OBJ-1:0]  left_x,
  output logic [10*NUM_OBJ-1:0]  right_x,
  output logic [9*NUM_OBJ-1:0]   top_y,
  output logic [9*NUM_OBJ-1:0]   bottom_y,
  output logic [NUM_OBJ-1:0]     obj_valid,
  output logic [NUM_OBJ-1:0]     pending
);

  localparam int PW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic signed [11:0] X_MAX = 12'(SCR_W - 1);
  localparam logic signed [11:0] Y_MAX = 12'(SCR_H - 1);

  typedef enum logic [1:0] {IDLE, GRANT, CALC, COMMIT} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        last_q, last_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [NUM_OBJ-1:0]   ack_q, ack_d;
  logic                 commit_req_q, commit_req_d;
  logic [9:0]           wx_q;
  logic [8:0]           wy_q;
  logic [5:0]           wh_q;
  logic [NUM_OBJ-1:0]   pending_q, valid_q;
  logic [9:0]           sh_l_q [NUM_OBJ];
  logic [9:0]           sh_r_q [NUM_OBJ];
  logic [8:0]           sh_t_q [NUM_OBJ];
  logic [8:0]           sh_b_q [NUM_OBJ];
  logic [9:0]           out_l_q [NUM_OBJ];
  logic [9:0]           out_r_q [NUM_OBJ];
  logic [8:0]           out_t_q [NUM_OBJ];
  logic [8:0]           out_b_q [NUM_OBJ];

  logic                 rr_found_s;
  logic [PW-1:0]        rr_idx_s, cand_s;
  logic [9:0]           cap_x_s;
  logic [8:0]           cap_y_s;
  logic [5:0]           cap_h_s;
  logic signed [11:0]   lo_x_s, hi_x_s, lo_y_s, hi_y_s;

  // Signed intermediates are wide enough that cx+half never wraps.
  function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
    if (v < 12'sd0)      clamp_x = 10'd0;
    else if (v > X_MAX)  clamp_x = X_MAX[9:0];
    else                 clamp_x = v[9:0];
  endfunction

  function automatic logic [8:0] clamp_y(input logic signed [11:0] v);
    if (v < 12'sd0)      clamp_y = 9'd0;
    else if (v > Y_MAX)  clamp_y = Y_MAX[8:0];
    else                 clamp_y = v[8:0];
  endfunction

  // Round-robin search starting one past the last granted object.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    cand_s     = '0;
    for (int i = 1; i <= NUM_OBJ; i++) begin
      cand_s = PW'((int'(last_q) + i) % NUM_OBJ);
      if (!rr_found_s && req[cand_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Request-field mux for the granted object, and the bound arithmetic.
  always_comb begin
    cap_x_s = '0;
    cap_y_s = '0;
    cap_h_s = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      cap_x_s = (grant_q == PW'(i)) ? req_x[i*10 +: 10]  : cap_x_s;
      cap_y_s = (grant_q == PW'(i)) ? req_y[i*9 +: 9]    : cap_y_s;
      cap_h_s = (grant_q == PW'(i)) ? req_half[i*6 +: 6] : cap_h_s;
    end
    lo_x_s = $signed({2'b00, wx_q}) - $signed({6'b000000, wh_q});
    hi_x_s = $signed({2'b00, wx_q}) + $signed({6'b000000, wh_q});
    lo_y_s = $signed({3'b000, wy_q}) - $signed({6'b000000, wh_q});
    hi_y_s = $signed({3'b000, wy_q}) + $signed({6'b000000, wh_q});
  end

  // FSM next-state and control decode.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    ack_d        = '0;
    commit_req_d = commit_req_q;
    case (state_q)
      IDLE: begin
        if (screenEnd) begin
          state_d = COMMIT;
        end else if (rr_found_s) begin
          grant_d = rr_idx_s;
          last_d  = rr_idx_s;
          ack_d   = NUM_OBJ'(1) << rr_idx_s;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        commit_req_d = commit_req_q | screenEnd;
        state_d      = CALC;
      end
      CALC: begin
        if (screenEnd || commit_req_q) state_d = COMMIT;
        else                           state_d = IDLE;
      end
      COMMIT: begin
        commit_req_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_q       <= PW'(NUM_OBJ - 1);
      grant_q      <= '0;
      ack_q        <= '0;
      commit_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      commit_req_q <= commit_req_d;
    end
  end

  // Working capture, shadow write and frame-boundary commit.
  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      wx_q      <= '0;
      wy_q      <= '0;
      wh_q      <= '0;
      pending_q <= '0;
      valid_q   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_l_q[i]  <= '0;
        sh_r_q[i]  <= '0;
        sh_t_q[i]  <= '0;
        sh_b_q[i]  <= '0;
        out_l_q[i] <= '0;
        out_r_q[i] <= '0;
        out_t_q[i] <= '0;
        out_b_q[i] <= '0;
      end
    end else begin
      case (state_q)
        GRANT: begin
          wx_q <= cap_x_s;
          wy_q <= cap_y_s;
          wh_q <= cap_h_s;
        end
        CALC: begin
          sh_l_q[grant_q]    <= clamp_x(lo_x_s);
          sh_r_q[grant_q]    <= clamp_x(hi_x_s);
          sh_t_q[grant_q]    <= clamp_y(lo_y_s);
          sh_b_q[grant_q]    <= clamp_y(hi_y_s);
          pending_q[grant_q] <= 1'b1;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_OBJ; i++) begin
            if (pending_q[i]) begin
              out_l_q[i]   <= sh_l_q[i];
              out_r_q[i]   <= sh_r_q[i];
              out_t_q[i]   <= sh_t_q[i];
              out_b_q[i]   <= sh_b_q[i];
              pending_q[i] <= 1'b0;
              valid_q[i]   <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pack the committed bounds onto the output buses.
  always_comb begin
    left_x   = '0;
    right_x  = '0;
    top_y    = '0;
    bottom_y = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      left_x[i*10 +: 10]  = out_l_q[i];
      right_x[i*10 +: 10] = out_r_q[i];
      top_y[i*9 +: 9]     = out_t_q[i];
      bottom_y[i*9 +: 9]  = out_b_q[i];
    end
  end

  assign ack       = ack_q;
  assign pending   = pending_q;
  assign obj_valid = valid_q;

endmodule

// File: tb/tb_box_update_sched.sv
// Randomized scoreboard bench for box_update_sched: a queue of expected grants
// is filled at request time and drained by a monitor watching ack.
module tb_box_update_sched;
  localparam int N = 4;
  localparam int W = 640;
  localparam int H = 480;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           se = 1'b0;
  logic [N-1:0]   req = '0;
  logic [10*N-1:0] rx = '0;
  logic [9*N-1:0]  ry = '0;
  logic [6*N-1:0]  rh = '0;
  logic [N-1:0]   ack, obj_valid, pending;
  logic [10*N-1:0] left_x, right_x;
  logic [9*N-1:0]  top_y, bottom_y;

  box_update_sched #(.NUM_OBJ(N), .SCR_W(W), .SCR_H(H)) dut (
    .clk_25mHz(clk), .reset(rst_n), .screenEnd(se), .req(req),
    .req_x(rx), .req_y(ry), .req_half(rh), .ack(ack),
    .left_x(left_x), .right_x(right_x), .top_y(top_y), .bottom_y(bottom_y),
    .obj_valid(obj_valid), .pending(pending));

  always #20 clk = ~clk;

  typedef struct { int idx; int l; int r; int t; int b; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int m_sl[N], m_sr[N], m_st[N], m_sb[N];
  int m_ol[N], m_or[N], m_ot[N], m_ob[N];
  bit m_pend[N], m_valid[N];
  int m_last;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, want);
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic set_obj(input int i, input int x, input int y, input int h);
    rx[i*10 +: 10] = x[9:0];
    ry[i*9 +: 9]   = y[8:0];
    rh[i*6 +: 6]   = h[5:0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sl[i] = 0; m_sr[i] = 0; m_st[i] = 0; m_sb[i] = 0;
      m_ol[i] = 0; m_or[i] = 0; m_ot[i] = 0; m_ob[i] = 0;
      m_pend[i] = 1'b0; m_valid[i] = 1'b0;
    end
    m_last = N - 1;
    q.delete();
  endtask

  task automatic model_commit();
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) begin
        m_ol[i] = m_sl[i]; m_or[i] = m_sr[i]; m_ot[i] = m_st[i]; m_ob[i] = m_sb[i];
        m_pend[i] = 1'b0; m_valid[i] = 1'b1;
      end
    end
  endtask

  // Expected grant order: requested objects in cyclic order after the last grant.
  task automatic push_expected(input logic [N-1:0] mask);
    exp_t e;
    int base;
    base = m_last;
    for (int k = 1; k <= N; k++) begin
      int i;
      int x, y, h;
      i = (base + k) % N;
      if (mask[i]) begin
        x = int'(rx[i*10 +: 10]); y = int'(ry[i*9 +: 9]); h = int'(rh[i*6 +: 6]);
        e.idx = i;
        e.l = clampi(x - h, W - 1); e.r = clampi(x + h, W - 1);
        e.t = clampi(y - h, H - 1); e.b = clampi(y + h, H - 1);
        q.push_back(e);
        m_last = i;
      end
    end
  endtask

  task automatic check_outputs(input string nm);
    logic [10*N-1:0] el, er;
    logic [9*N-1:0]  et, eb;
    logic [N-1:0]    ev, ep;
    for (int i = 0; i < N; i++) begin
      el[i*10 +: 10] = m_ol[i][9:0]; er[i*10 +: 10] = m_or[i][9:0];
      et[i*9 +: 9]   = m_ot[i][8:0]; eb[i*9 +: 9]   = m_ob[i][8:0];
      ev[i] = m_valid[i]; ep[i] = m_pend[i];
    end
    check({nm, "_left"}, left_x, el);
    check({nm, "_right"}, right_x, er);
    check({nm, "_top"}, top_y, et);
    check({nm, "_bottom"}, bottom_y, eb);
    check({nm, "_valid"}, obj_valid, ev);
    check({nm, "_pending"}, pending, ep);
  endtask

  // se_mode 1: screenEnd with the request; 2: screenEnd during CALC of first grant.
  task automatic burst(input logic [N-1:0] mask, input bit rnd, input int se_mode);
    int se_at;
    bit first;
    int cyc;
    if (rnd) begin
      for (int i = 0; i < N; i++)
        if (mask[i]) begin
          int h;
          h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
          set_obj(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)), h);
        end
    end
    push_expected(mask);
    @(negedge clk);
    req = mask;
    if (se_mode == 1) begin
      se = 1'b1;
      model_commit();
    end
    se_at = -1;
    first = 1'b1;
    cyc = 0;
    while (req != '0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      se = 1'b0;
      if (se_at == cyc) begin
        se = 1'b1;
        model_commit();
      end
      if ((ack & req) != '0) begin
        req = req & ~ack;
        if (se_mode == 2 && first) se_at = cyc + 1;
        first = 1'b0;
      end
    end
    check("burst_done", req, '0);
    repeat (4) @(negedge clk);
    se = 1'b0;
    check("acks_drained", q.size(), 0);
  endtask

  task automatic do_commit(input string nm);
    @(negedge clk);
    se = 1'b1;
    model_commit();
    @(negedge clk);
    se = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs(nm);
  endtask

  // Monitor: every ack must match the head of the expected-grant queue.
  always @(negedge clk) begin
    if (rst_n && ack != '0) begin
      if (q.size() == 0) begin
        check("unexpected_ack", ack, '0);
      end else begin
        mon_e = q.pop_front();
        check("ack_order", ack, 64'(1) << mon_e.idx);
        m_sl[mon_e.idx] = mon_e.l; m_sr[mon_e.idx] = mon_e.r;
        m_st[mon_e.idx] = mon_e.t; m_sb[mon_e.idx] = mon_e.b;
        m_pend[mon_e.idx] = 1'b1;
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_ack", ack, '0);
    rst_n = 1'b1;

    // Overwrite before commit; object 3 stays untouched.
    set_obj(0, 300, 100, 10);
    burst(4'b0001, 1'b0, 0);
    set_obj(0, 50, 60, 5);
    burst(4'b0001, 1'b0, 0);
    do_commit("overwrite");
    check("ovw_left0", left_x[9:0], 10'd45);
    check("ovw_valid3", obj_valid[3], 1'b0);
    check("ovw_left3", left_x[39:30], 10'd0);

    // Single update, then commit.
    set_obj(1, 100, 200, 25);
    burst(4'b0010, 1'b0, 0);
    check_outputs("single_pre");
    check("single_pre_left1", left_x[19:10], 10'd0);
    do_commit("single");
    check("single_left1", left_x[19:10], 10'd75);
    check("single_right1", right_x[19:10], 10'd125);
    check("single_top1", top_y[17:9], 9'd175);
    check("single_bottom1", bottom_y[17:9], 9'd225);

    // Clamping at every edge, plus half=0 beyond the right edge.
    set_obj(2, 10, 470, 30);
    set_obj(0, 630, 240, 20);
    set_obj(3, 700, 5, 0);
    burst(4'b1101, 1'b0, 0);
    do_commit("clamp");
    check("clamp_left2", left_x[29:20], 10'd0);
    check("clamp_right2", right_x[29:20], 10'd40);
    check("clamp_top2", top_y[26:18], 9'd440);
    check("clamp_bottom2", bottom_y[26:18], 9'd479);
    check("clamp_right0", right_x[9:0], 10'd639);
    check("clamp_h0_left3", left_x[39:30], 10'd639);
    check("clamp_h0_top3", top_y[35:27], 9'd5);

    // Reset while in GRANT aborts everything.
    push_expected(4'b0100);
    @(negedge clk);
    req = 4'b0100;
    for (int c = 0; c < 10 && ack == '0; c++) @(negedge clk);
    check("rst_ack_seen", ack, 4'b0100);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    check("midreset_ack", ack, '0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin order from reset, then a sparse second burst.
    burst(4'b1111, 1'b1, 0);
    burst(4'b0101, 1'b1, 0);
    do_commit("rr");

    // screenEnd together with a request, and screenEnd during CALC.
    burst(4'b0100, 1'b1, 1);
    check_outputs("se_idle");
    do_commit("se_idle_post");
    burst(4'b0010, 1'b1, 2);
    check_outputs("se_calc");

    for (int it = 0; it < 30; it++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      burst(m, 1'b1, ($urandom_range(0, 5) == 0) ? 2 : 0);
      if ($urandom_range(0, 1) == 1) do_commit("rand");
      else check_outputs("rand_hold");
    end
    do_commit("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
